psr_unit: RTL and testbench

Processor State Register unit for the SPARC datapath, directly downstream of the 32-bit ALU. It registers the ALU's N/Z/V/C flags into the integer condition codes (icc) and feeds C back as the ALU's `carry` input. It also maintains S/PS/ET/PIL/EF, the current window pointer (CWP) and the window invalid mask (WIM). It evaluates Bicc branch conditions, and raises window-overflow, window-underflow and illegal-instruction trap pulses for SAVE, RESTORE and RETT.

---
 rtl/sparc_pkg.sv | 51 +++++
 rtl/psr_cond_eval.sv | 39 +++
 rtl/psr_unit.sv | 176 +++++++++++++++++
 tb/tb_psr_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC definitions: PSR field positions, Bicc codes, ALU cc-op decode.
package sparc_pkg;

    localparam int DEF_NWINDOWS = 8;

    localparam int PSR_IMPL_LSB = 28;
    localparam int PSR_VER_LSB  = 24;
    localparam int PSR_ICC_LSB  = 20;
    localparam int PSR_EF       = 12;
    localparam int PSR_PIL_LSB  = 8;
    localparam int PSR_S        = 7;
    localparam int PSR_PS       = 6;
    localparam int PSR_ET       = 5;
    localparam int PSR_CWP_LSB  = 0;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    typedef enum logic [3:0] {
        BN   = 4'h0,
        BE   = 4'h1,
        BLE  = 4'h2,
        BL   = 4'h3,
        BLEU = 4'h4,
        BCS  = 4'h5,
        BNEG = 4'h6,
        BVS  = 4'h7,
        BA   = 4'h8,
        BNE  = 4'h9,
        BG   = 4'hA,
        BGE  = 4'hB,
        BGU  = 4'hC,
        BCC  = 4'hD,
        BPOS = 4'hE,
        BVC  = 4'hF
    } bicc_e;

    localparam logic [1:0] OP_CC_GRP   = 2'b01;
    localparam logic [1:0] OP_ARITH_LO = 2'b00;

    localparam logic [5:0] OP_ADDCC  = 6'b010000;
    localparam logic [5:0] OP_ANDCC  = 6'b010001;
    localparam logic [5:0] OP_ORCC   = 6'b010010;
    localparam logic [5:0] OP_XORCC  = 6'b010011;
    localparam logic [5:0] OP_SUBCC  = 6'b010100;
    localparam logic [5:0] OP_ADDXCC = 6'b011000;
    localparam logic [5:0] OP_SUBXCC = 6'b011100;

endpackage

// File: rtl/psr_cond_eval.sv
// Bicc condition evaluator: integer condition codes x cond field -> taken.
module psr_cond_eval
    import sparc_pkg::*;
(
    input  logic [3:0] icc_i,
    input  logic [3:0] cond_i,
    output logic       cond_true_o
);

    logic n, z, v, c;

    assign n = icc_i[ICC_N];
    assign z = icc_i[ICC_Z];
    assign v = icc_i[ICC_V];
    assign c = icc_i[ICC_C];

    always_comb begin
        cond_true_o = 1'b0;
        unique case (bicc_e'(cond_i))
            BN:   cond_true_o = 1'b0;
            BE:   cond_true_o = z;
            BLE:  cond_true_o = z | (n ^ v);
            BL:   cond_true_o = n ^ v;
            BLEU: cond_true_o = c | z;
            BCS:  cond_true_o = c;
            BNEG: cond_true_o = n;
            BVS:  cond_true_o = v;
            BA:   cond_true_o = 1'b1;
            BNE:  cond_true_o = ~z;
            BG:   cond_true_o = ~(z | (n ^ v));
            BGE:  cond_true_o = ~(n ^ v);
            BGU:  cond_true_o = ~(c | z);
            BCC:  cond_true_o = ~c;
            BPOS: cond_true_o = ~n;
            BVC:  cond_true_o = ~v;
        endcase
    end

endmodule

// File: rtl/psr_unit.sv
// Processor State Register: icc, supervisor/trap state, CWP and WIM,
// window overflow/underflow checks and Bicc condition evaluation.
module psr_unit
    import sparc_pkg::*;
#(
    parameter int         NWINDOWS = DEF_NWINDOWS,
    parameter logic [3:0] IMPL     = 4'h0,
    parameter logic [3:0] VER      = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          alu_opcode,
    input  logic                alu_valid,
    input  logic                n_in,
    input  logic                z_in,
    input  logic                v_in,
    input  logic                c_in,
    input  logic                wrpsr,
    input  logic                wrwim,
    input  logic [31:0]         wr_data,
    input  logic                save,
    input  logic                restore,
    input  logic                rett,
    input  logic                trap_entry,
    input  logic [3:0]          cond,
    output logic [31:0]         psr,
    output logic [NWINDOWS-1:0] wim,
    output logic [4:0]          cwp,
    output logic                carry,
    output logic                cond_true,
    output logic                wof_trap,
    output logic                wuf_trap,
    output logic                illegal_trap
);

    localparam logic [4:0] WMASK = 5'(NWINDOWS - 1);
    localparam logic [5:0] NW6   = 6'(NWINDOWS);

    logic [3:0]          icc_q, icc_d;
    logic                ef_q, ef_d;
    logic [3:0]          pil_q, pil_d;
    logic                s_q, s_d;
    logic                ps_q, ps_d;
    logic                et_q, et_d;
    logic [4:0]          cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                wof_q, wof_d;
    logic                wuf_q, wuf_d;
    logic                ill_q, ill_d;

    logic [4:0]  cwp_inc, cwp_dec;
    logic [31:0] wim_ext;
    logic        inc_inval, dec_inval;
    logic        cc_op, arith_cc;
    logic        unused_bits;

    assign cwp_inc   = (cwp_q + 5'd1) & WMASK;
    assign cwp_dec   = (cwp_q - 5'd1) & WMASK;
    assign wim_ext   = 32'(wim_q);
    assign inc_inval = wim_ext[cwp_inc];
    assign dec_inval = wim_ext[cwp_dec];

    assign cc_op    = alu_valid && (alu_opcode[5:4] == OP_CC_GRP);
    assign arith_cc = (alu_opcode[1:0] == OP_ARITH_LO);

    assign unused_bits = ^{wr_data[31:24], wr_data[19:13], alu_opcode[3:2]};

    always_comb begin
        icc_d = icc_q;
        ef_d  = ef_q;
        pil_d = pil_q;
        s_d   = s_q;
        ps_d  = ps_q;
        et_d  = et_q;
        cwp_d = cwp_q;
        wim_d = wim_q;
        wof_d = 1'b0;
        wuf_d = 1'b0;
        ill_d = 1'b0;

        if (wrwim) begin
            wim_d = wr_data[NWINDOWS-1:0];
        end

        // Only WRPSR competes with the ALU for icc
        if (cc_op && !wrpsr) begin
            icc_d[ICC_N] = n_in;
            icc_d[ICC_Z] = z_in;
            icc_d[ICC_V] = arith_cc ? v_in : 1'b0;
            icc_d[ICC_C] = arith_cc ? c_in : 1'b0;
        end

        if (trap_entry) begin
            et_d  = 1'b0;
            ps_d  = s_q;
            s_d   = 1'b1;
            cwp_d = cwp_dec;
        end else if (rett) begin
            if (et_q) begin
                ill_d = 1'b1;
            end else if (inc_inval) begin
                wuf_d = 1'b1;
            end else begin
                cwp_d = cwp_inc;
                s_d   = ps_q;
                et_d  = 1'b1;
            end
        end else if (wrpsr) begin
            icc_d = wr_data[PSR_ICC_LSB +: 4];
            ef_d  = wr_data[PSR_EF];
            pil_d = wr_data[PSR_PIL_LSB +: 4];
            s_d   = wr_data[PSR_S];
            ps_d  = wr_data[PSR_PS];
            et_d  = wr_data[PSR_ET];
            if ({1'b0, wr_data[PSR_CWP_LSB +: 5]} < NW6) begin
                cwp_d = wr_data[PSR_CWP_LSB +: 5];
            end
        end else if (save && !restore) begin
            if (dec_inval) begin
                wof_d = 1'b1;
            end else begin
                cwp_d = cwp_dec;
            end
        end else if (restore && !save) begin
            if (inc_inval) begin
                wuf_d = 1'b1;
            end else begin
                cwp_d = cwp_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icc_q <= 4'b0;
            ef_q  <= 1'b0;
            pil_q <= 4'b0;
            s_q   <= 1'b1;
            ps_q  <= 1'b0;
            et_q  <= 1'b0;
            cwp_q <= 5'd0;
            wim_q <= '0;
            wof_q <= 1'b0;
            wuf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            icc_q <= icc_d;
            ef_q  <= ef_d;
            pil_q <= pil_d;
            s_q   <= s_d;
            ps_q  <= ps_d;
            et_q  <= et_d;
            cwp_q <= cwp_d;
            wim_q <= wim_d;
            wof_q <= wof_d;
            wuf_q <= wuf_d;
            ill_q <= ill_d;
        end
    end

    psr_cond_eval u_cond (
        .icc_i       (icc_q),
        .cond_i      (cond),
        .cond_true_o (cond_true)
    );

    assign psr = {IMPL, VER, icc_q, 7'b0, ef_q, pil_q,
                  s_q, ps_q, et_q, cwp_q};
    assign wim          = wim_q;
    assign cwp          = cwp_q;
    assign carry        = icc_q[ICC_C];
    assign wof_trap     = wof_q;
    assign wuf_trap     = wuf_q;
    assign illegal_trap = ill_q;

endmodule

// File: tb/tb_psr_unit.sv
// Scoreboard bench for psr_unit: directed steps push expected state,
// a monitor pops one entry per clock and compares.
module tb_psr_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  alu_opcode;
    logic        alu_valid;
    logic        n_in, z_in, v_in, c_in;
    logic        wrpsr, wrwim;
    logic [31:0] wr_data;
    logic        save, restore, rett, trap_entry;
    logic [3:0]  cond;
    logic [31:0] psr;
    logic [7:0]  wim;
    logic [4:0]  cwp;
    logic        carry, cond_true;
    logic        wof_trap, wuf_trap, illegal_trap;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] psr;
        logic [7:0]  wim;
        logic        ct;
        logic        wof;
        logic        wuf;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    psr_unit #(.NWINDOWS(8), .IMPL(4'h0), .VER(4'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_opcode   (alu_opcode),
        .alu_valid    (alu_valid),
        .n_in         (n_in),
        .z_in         (z_in),
        .v_in         (v_in),
        .c_in         (c_in),
        .wrpsr        (wrpsr),
        .wrwim        (wrwim),
        .wr_data      (wr_data),
        .save         (save),
        .restore      (restore),
        .rett         (rett),
        .trap_entry   (trap_entry),
        .cond         (cond),
        .psr          (psr),
        .wim          (wim),
        .cwp          (cwp),
        .carry        (carry),
        .cond_true    (cond_true),
        .wof_trap     (wof_trap),
        .wuf_trap     (wuf_trap),
        .illegal_trap (illegal_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        rst = 0; alu_opcode = 6'b0; alu_valid = 0;
        {n_in, z_in, v_in, c_in} = 4'b0;
        wrpsr = 0; wrwim = 0; wr_data = 32'h0;
        save = 0; restore = 0; rett = 0; trap_entry = 0;
        cond = 4'h0;
    endtask

    task automatic alu(input logic [5:0] op, input logic [3:0] f);
        alu_opcode = op;
        alu_valid  = 1'b1;
        {n_in, z_in, v_in, c_in} = f;
    endtask

    task automatic expect_st(input logic [31:0] p, input logic [7:0] w,
                             input logic ct, input logic [2:0] tr);
        exp_t e;
        e.id  = 8'(step_id);
        e.psr = p;
        e.wim = w;
        e.ct  = ct;
        e.wof = tr[2];
        e.wuf = tr[1];
        e.ill = tr[0];
        q.push_back(e);
        step_id++;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (psr !== e.psr || wim !== e.wim ||
                    cwp !== e.psr[4:0] || carry !== e.psr[20] ||
                    cond_true !== e.ct || wof_trap !== e.wof ||
                    wuf_trap !== e.wuf || illegal_trap !== e.ill) begin
                    errors++;
                    $display("FAIL step%0d got psr=%h wim=%h cwp=%0d c=%b ct=%b traps=%b%b%b exp psr=%h wim=%h cwp=%0d c=%b ct=%b traps=%b%b%b",
                             e.id, psr, wim, cwp, carry, cond_true,
                             wof_trap, wuf_trap, illegal_trap,
                             e.psr, e.wim, e.psr[4:0], e.psr[20], e.ct,
                             e.wof, e.wuf, e.ill);
                end
            end
        end
    end

    initial begin
        int waited;
        clr();
        // 0: reset
        @(negedge clk); clr(); rst = 1;
        expect_st(32'h0000_0080, 8'h00, 1'b0, 3'b000);
        // 1: SUBcc 0101, cond BE
        @(negedge clk); clr(); alu(6'b010100, 4'b0101); cond = 4'h1;
        expect_st(32'h0050_0080, 8'h00, 1'b1, 3'b000);
        // 2: ANDcc n=1 z=0, V/C cleared; cond BNEG
        @(negedge clk); clr(); alu(6'b010001, 4'b1011); cond = 4'h6;
        expect_st(32'h0080_0080, 8'h00, 1'b1, 3'b000);
        // 3: shift op leaves icc; cond BPOS
        @(negedge clk); clr(); alu(6'b100000, 4'b0111); cond = 4'hE;
        expect_st(32'h0080_0080, 8'h00, 1'b0, 3'b000);
        // 4: ADDcc not valid; cond BA
        @(negedge clk); clr(); alu(6'b010000, 4'b0001);
        alu_valid = 0; cond = 4'h8;
        expect_st(32'h0080_0080, 8'h00, 1'b1, 3'b000);
        // 5: WIM = 0x80
        @(negedge clk); clr(); wrwim = 1; wr_data = 32'h0000_0080;
        expect_st(32'h0080_0080, 8'h80, 1'b0, 3'b000);
        // 6: SAVE into invalid window 7
        @(negedge clk); clr(); save = 1;
        expect_st(32'h0080_0080, 8'h80, 1'b0, 3'b100);
        // 7: pulse ends
        @(negedge clk); clr();
        expect_st(32'h0080_0080, 8'h80, 1'b0, 3'b000);
        // 8: WIM = 0
        @(negedge clk); clr(); wrwim = 1; wr_data = 32'h0;
        expect_st(32'h0080_0080, 8'h00, 1'b0, 3'b000);
        // 9: SAVE wraps to 7
        @(negedge clk); clr(); save = 1;
        expect_st(32'h0080_0087, 8'h00, 1'b0, 3'b000);
        // 10: WRPSR, read-only bits ignored
        @(negedge clk); clr(); wrpsr = 1; wr_data = 32'hFF0F_F523;
        expect_st(32'h0000_1523, 8'h00, 1'b0, 3'b000);
        // 11: trap entry
        @(negedge clk); clr(); trap_entry = 1;
        expect_st(32'h0000_1582, 8'h00, 1'b0, 3'b000);
        // 12: RETT
        @(negedge clk); clr(); rett = 1;
        expect_st(32'h0000_1523, 8'h00, 1'b0, 3'b000);
        // 13: RETT with ET=1
        @(negedge clk); clr(); rett = 1;
        expect_st(32'h0000_1523, 8'h00, 1'b0, 3'b001);
        // 14
        @(negedge clk); clr();
        expect_st(32'h0000_1523, 8'h00, 1'b0, 3'b000);
        // 15: WRPSR beats ADDcc for icc; cond BVS
        @(negedge clk); clr(); alu(6'b010000, 4'b1100);
        wrpsr = 1; wr_data = 32'h0020_1523; cond = 4'h7;
        expect_st(32'h0020_1523, 8'h00, 1'b1, 3'b000);
        // 16: save+restore together
        @(negedge clk); clr(); save = 1; restore = 1;
        expect_st(32'h0020_1523, 8'h00, 1'b0, 3'b000);
        // 17: WRPSR with CWP=9 ignored for CWP only; cond BVC
        @(negedge clk); clr(); wrpsr = 1; wr_data = 32'h0000_0089;
        cond = 4'hF;
        expect_st(32'h0000_0083, 8'h00, 1'b1, 3'b000);
        // 18: RESTORE checks pre-edge WIM while WRWIM lands
        @(negedge clk); clr(); restore = 1; wrwim = 1;
        wr_data = 32'h0000_0010;
        expect_st(32'h0000_0084, 8'h10, 1'b0, 3'b000);
        // 19
        @(negedge clk); clr(); wrwim = 1; wr_data = 32'h0000_0020;
        expect_st(32'h0000_0084, 8'h20, 1'b0, 3'b000);
        // 20: RESTORE into invalid window 5
        @(negedge clk); clr(); restore = 1;
        expect_st(32'h0000_0084, 8'h20, 1'b0, 3'b010);
        // 21
        @(negedge clk); clr();
        expect_st(32'h0000_0084, 8'h20, 1'b0, 3'b000);
        // 22: RETT with ET=0 into invalid window
        @(negedge clk); clr(); rett = 1;
        expect_st(32'h0000_0084, 8'h20, 1'b0, 3'b010);
        // 23: window 3 invalid
        @(negedge clk); clr(); wrwim = 1; wr_data = 32'h0000_0008;
        expect_st(32'h0000_0084, 8'h08, 1'b0, 3'b000);
        // 24: reset with SAVE into invalid window
        @(negedge clk); clr(); rst = 1; save = 1;
        expect_st(32'h0000_0080, 8'h00, 1'b0, 3'b000);
        // 25
        @(negedge clk); clr();
        expect_st(32'h0000_0080, 8'h00, 1'b0, 3'b000);

        @(negedge clk); clr();
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
